// File: rtl/cpu_trace_if.sv
// Character stream into the trace checker and the per-line classification results out of it.
interface cpu_trace_if #(
  parameter int CNT_W = 16
) ();
  logic [7:0]       char;
  logic [1:0]       format_type;
  logic [3:0]       error_code;
  logic [CNT_W-1:0] good_lines;
  logic [CNT_W-1:0] bad_lines;

  modport master (output char, input format_type, error_code, good_lines, bad_lines);
  modport slave  (input char, output format_type, error_code, good_lines, bad_lines);
endinterface

// File: rtl/cpu_trace_checker.sv
// Streaming parser/range checker for CPU trace lines "^T@P: $R <= D#" and "^T@P: *A <= D#".
// Optional good/bad line counters are built only when CPU_TRACE_LINE_COUNT_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------
// IDLE      | waiting for '^'
// TIME      | decimal time digits, ended by '@'
// PC        | hex PC digits, ended by ':'
// COLON_SP  | spaces, then '$' (register) or '*' (memory)
// REG       | decimal register number
// MEM       | hex memory address
// PRE_LT    | spaces before '<'
// LT_EQ     | expecting '='
// POST_EQ   | spaces before data
// DATA      | hex data digits, ended by '#'
// DONE1     | register-write line completed
// DONE2     | memory-write line completed
module cpu_trace_checker #(
  parameter int          TIME_MAX_DIG = 4,
  parameter int          REG_MAX_DIG  = 4,
  parameter int          HEX_DIG      = 8,
  parameter bit          UPPER_HEX    = 1'b0,
  parameter logic [31:0] PC_LO        = 32'h0000_3000,
  parameter logic [31:0] PC_HI        = 32'h0000_6ffc,
  parameter logic [31:0] ADDR_HI      = 32'h0000_2ffc,
  parameter int          REG_NUM      = 32,
  parameter int          CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  cpu_trace_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_COLON_SP, S_REG, S_MEM,
    S_PRE_LT, S_LT_EQ, S_POST_EQ, S_DATA, S_DONE1, S_DONE2
  } state_t;

  localparam logic [7:0]  TIME_MAX_C = 8'(TIME_MAX_DIG);
  localparam logic [7:0]  REG_MAX_C  = 8'(REG_MAX_DIG);
  localparam logic [7:0]  HEX_C      = 8'(HEX_DIG);
  localparam logic [13:0] REG_NUM_C  = 14'(REG_NUM);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] pc_acc;
  logic [31:0] addr_acc;
  logic [13:0] reg_acc;
  logic        is_mem;
  logic [1:0]  format_type;
  logic [3:0]  error_code;

  logic [7:0]  c;
  logic        is_dig, is_hex, legal, accept;
  logic [3:0]  nib;
  logic [3:0]  line_err;

  assign c = bus.char;

  always_comb begin
    is_dig = (c >= "0") && (c <= "9");
    is_hex = is_dig || ((c >= "a") && (c <= "f")) ||
             (UPPER_HEX && (c >= "A") && (c <= "F"));
    // 'a'/'A' have low nibble 1, so adding 9 gives 10
    nib    = is_dig ? c[3:0] : c[3:0] + 4'd9;
    accept = (state == S_DATA) && (c == "#") && (cnt == HEX_C);

    line_err    = 4'd0;
    line_err[0] = (pc_acc < PC_LO) || (pc_acc > PC_HI) || (pc_acc[1:0] != 2'd0);
    line_err[1] = is_mem && ((addr_acc > ADDR_HI) || (addr_acc[1:0] != 2'd0));
    line_err[2] = !is_mem && (reg_acc >= REG_NUM_C);

    legal = 1'b0;
    case (state)
      S_TIME:     legal = (is_dig && cnt < TIME_MAX_C) || (c == "@" && cnt != 8'd0);
      S_PC:       legal = (is_hex && cnt < HEX_C) || (c == ":" && cnt == HEX_C);
      S_COLON_SP: legal = (c == " ") || (c == "$") || (c == "*");
      S_REG:      legal = (is_dig && cnt < REG_MAX_C) || ((c == " " || c == "<") && cnt != 8'd0);
      S_MEM:      legal = (is_hex && cnt < HEX_C) || ((c == " " || c == "<") && cnt == HEX_C);
      S_PRE_LT:   legal = (c == " ") || (c == "<");
      S_LT_EQ:    legal = (c == "=");
      S_POST_EQ:  legal = (c == " ") || is_hex;
      S_DATA:     legal = (is_hex && cnt < HEX_C) || accept;
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE; cnt <= '0; pc_acc <= '0; addr_acc <= '0; reg_acc <= '0;
      is_mem <= 1'b0; format_type <= 2'd0; error_code <= 4'd0;
    end else begin
      format_type <= 2'd0;
      error_code  <= 4'd0;
      if (c == "^" || !legal) begin
        // '^' resyncs from anywhere; any other illegal char drops the line
        state <= (c == "^") ? S_TIME : S_IDLE;
        cnt <= '0; pc_acc <= '0; addr_acc <= '0; reg_acc <= '0; is_mem <= 1'b0;
      end else begin
        case (state)
          S_TIME:
            if (c == "@") begin state <= S_PC; cnt <= '0; end
            else cnt <= cnt + 8'd1;
          S_PC:
            if (c == ":") begin state <= S_COLON_SP; cnt <= '0; end
            else begin pc_acc <= {pc_acc[27:0], nib}; cnt <= cnt + 8'd1; end
          S_COLON_SP:
            if (c == "$") begin state <= S_REG; is_mem <= 1'b0; end
            else if (c == "*") begin state <= S_MEM; is_mem <= 1'b1; end
          S_REG:
            if (is_dig) begin
              reg_acc <= reg_acc * 14'd10 + {10'd0, nib};
              cnt     <= cnt + 8'd1;
            end else begin
              state <= (c == "<") ? S_LT_EQ : S_PRE_LT;
              cnt   <= '0;
            end
          S_MEM:
            if (is_hex) begin
              addr_acc <= {addr_acc[27:0], nib};
              cnt      <= cnt + 8'd1;
            end else begin
              state <= (c == "<") ? S_LT_EQ : S_PRE_LT;
              cnt   <= '0;
            end
          S_PRE_LT:
            if (c == "<") state <= S_LT_EQ;
          S_LT_EQ:
            state <= S_POST_EQ;
          S_POST_EQ:
            if (is_hex) begin state <= S_DATA; cnt <= 8'd1; end
          S_DATA:
            if (accept) begin
              state       <= is_mem ? S_DONE2 : S_DONE1;
              format_type <= is_mem ? 2'd2 : 2'd1;
              error_code  <= line_err;
            end else cnt <= cnt + 8'd1;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.format_type = format_type;
  assign bus.error_code  = error_code;

`ifdef CPU_TRACE_LINE_COUNT_EN
  logic [CNT_W-1:0] good_q, bad_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (accept) begin
      if (line_err == 4'd0) begin
        if (good_q != {CNT_W{1'b1}}) good_q <= good_q + 1'b1;
      end else begin
        if (bad_q != {CNT_W{1'b1}}) bad_q <= bad_q + 1'b1;
      end
    end
  end

  assign bus.good_lines = good_q;
  assign bus.bad_lines  = bad_q;
`else
  assign bus.good_lines = '0;
  assign bus.bad_lines  = '0;
`endif

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Scoreboard bench for cpu_trace_checker: expected line results are queued as lines are sent
// and popped whenever the checker reports a completed line.
module tb_cpu_trace_checker;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cpu_trace_if #(.CNT_W(16)) bus ();

  cpu_trace_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef CPU_TRACE_LINE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int         vectors     = 0;
  int         miscompares = 0;
  int         exp_good    = 0;
  int         exp_bad     = 0;
  logic [5:0] exp_q[$];

  task automatic drive_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      bus.char = s[i];
    end
  endtask

  task automatic expect_line(input logic [1:0] t, input logic [3:0] e);
    exp_q.push_back({t, e});
    if (CNT_EN) begin
      if (e == 4'd0) exp_good++;
      else           exp_bad++;
    end
  endtask

  task automatic flush();
    drive_str("....");
  endtask

  // Every cycle: a reported line must match the oldest expectation; otherwise error_code must be 0.
  always @(negedge clk) begin : monitor
    logic [5:0] exp_v;
    if (bus.format_type != 2'd0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_line: got type=%0d err=%b, expected no result",
                 bus.format_type, bus.error_code);
      end else begin
        exp_v = exp_q.pop_front();
        if ({bus.format_type, bus.error_code} !== exp_v) begin
          miscompares++;
          $display("FAIL line_result: got type=%0d err=%b, expected type=%0d err=%b",
                   bus.format_type, bus.error_code, exp_v[5:4], exp_v[3:0]);
        end
      end
    end else begin
      vectors++;
      if (bus.error_code !== 4'd0) begin
        miscompares++;
        $display("FAIL idle_error_code: got %b, expected 0000", bus.error_code);
      end
    end
  end

  task automatic test_reset();
    reset    = 1'b1;
    bus.char = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.format_type !== 2'd0 || bus.error_code !== 4'd0 ||
        bus.good_lines !== 16'd0 || bus.bad_lines !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: got type=%0d err=%b good=%0d bad=%0d, expected all 0",
               bus.format_type, bus.error_code, bus.good_lines, bus.bad_lines);
    end
    reset = 1'b0;
  endtask

  task automatic test_reg_write();
    expect_line(2'd1, 4'b0000);
    drive_str("^10@00003010: $5 <= 0000abcd#");
    flush();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reg_write_missing: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (bus.good_lines !== 16'(exp_good) || bus.bad_lines !== 16'(exp_bad)) begin
      miscompares++;
      $display("FAIL reg_write_counts: got good=%0d bad=%0d, expected good=%0d bad=%0d",
               bus.good_lines, bus.bad_lines, exp_good, exp_bad);
    end
  endtask

  task automatic test_mem_write();
    expect_line(2'd2, 4'b0001);
    drive_str("^7@00003012:*00002ffc<=12345678#");
    flush();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mem_write_missing: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (bus.good_lines !== 16'(exp_good) || bus.bad_lines !== 16'(exp_bad)) begin
      miscompares++;
      $display("FAIL mem_write_counts: got good=%0d bad=%0d, expected good=%0d bad=%0d",
               bus.good_lines, bus.bad_lines, exp_good, exp_bad);
    end
  endtask

  task automatic test_back_to_back();
    expect_line(2'd1, 4'b0100);
    drive_str("^3@00003000: $32 <=  00000001#");
    expect_line(2'd2, 4'b0010);
    drive_str("^3@00003000: *00003000 <= 00000001#");
    expect_line(2'd2, 4'b0000);
    drive_str("^4@00006ffc:*00002ffc<=deadbeef#");
    expect_line(2'd1, 4'b0001);
    drive_str("^4@00007000: $31<= 00000000#");
    flush();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL back_to_back_missing: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (bus.good_lines !== 16'(exp_good) || bus.bad_lines !== 16'(exp_bad)) begin
      miscompares++;
      $display("FAIL back_to_back_counts: got good=%0d bad=%0d, expected good=%0d bad=%0d",
               bus.good_lines, bus.bad_lines, exp_good, exp_bad);
    end
  endtask

  task automatic test_overflow();
    drive_str("^12345@00003000: $1 <= 00000000#");
    flush();
    drive_str("^1@00003000: $1 <= 0000000#");
    flush();
    drive_str("^1@00003000: $12345 <= 00000000#");
    flush();
    drive_str("^1@00003000:  $1 < = 00000000#");
    flush();
    vectors++;
    if (bus.good_lines !== 16'(exp_good) || bus.bad_lines !== 16'(exp_bad)) begin
      miscompares++;
      $display("FAIL overflow_counts: got good=%0d bad=%0d, expected good=%0d bad=%0d",
               bus.good_lines, bus.bad_lines, exp_good, exp_bad);
    end
  endtask

  task automatic test_resync();
    expect_line(2'd1, 4'b0000);
    drive_str("^1@0000^2@00003000: $0 <= ffffffff#");
    flush();
    drive_str("^2@00003000: $0 <= FFFFFFFF#");
    flush();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL resync_missing: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (bus.good_lines !== 16'(exp_good) || bus.bad_lines !== 16'(exp_bad)) begin
      miscompares++;
      $display("FAIL resync_counts: got good=%0d bad=%0d, expected good=%0d bad=%0d",
               bus.good_lines, bus.bad_lines, exp_good, exp_bad);
    end
  endtask

  task automatic test_mid_reset();
    drive_str("^5@00003000: $1 ");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    drive_str("<= 00000000#");
    flush();
    vectors++;
    if (bus.good_lines !== 16'd0 || bus.bad_lines !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset_counts: got good=%0d bad=%0d, expected 0 0",
               bus.good_lines, bus.bad_lines);
    end
    expect_line(2'd2, 4'b0000);
    drive_str("^9@00006ffc: *00000000 <= 00000000#");
    flush();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_missing: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (bus.good_lines !== 16'(exp_good) || bus.bad_lines !== 16'(exp_bad)) begin
      miscompares++;
      $display("FAIL mid_reset_after_counts: got good=%0d bad=%0d, expected good=%0d bad=%0d",
               bus.good_lines, bus.bad_lines, exp_good, exp_bad);
    end
  endtask

  initial begin
    bus.char = 8'h00;
    test_reset();
    test_reg_write();
    test_mem_write();
    test_back_to_back();
    test_overflow();
    test_resync();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Streaming checker for single-cycle CPU trace lines. It receives one ASCII character per clock.
- It classifies each completed line as a register write or a memory write, then range-checks the decoded fields.
- It sits beside the CPU testbench output path and flags malformed or out-of-range trace records.
- It generalises the fixed-width format checker: digit widths, address windows and hex case are parameters, and semantic error reporting is added.

Parameters:
- TIME_MAX_DIG, 4, max decimal digits in the time field (min 1).
- REG_MAX_DIG, 4, max decimal digits in the register-number field (min 1).
- HEX_DIG, 8, exact hex digit count of the PC, address and data fields.
- UPPER_HEX, 0, 1 = accept A-F in addition to a-f.
- PC_LO, 32'h0000_3000, lowest legal PC (inclusive).
- PC_HI, 32'h0000_6ffc, highest legal PC (inclusive).
- ADDR_HI, 32'h0000_2ffc, highest legal memory address (lowest is 0).
- REG_NUM, 32, legal register numbers are 0..REG_NUM-1.
- CNT_W, 16, width of the line counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset; clock clk
- char  in  8  ASCII character, sampled every rising edge
- format_type  out  2  0 none, 1 register-write line, 2 memory-write line
- error_code  out  4  semantic errors of the just-completed line
- good_lines  out  CNT_W  lines completed with error_code==0
- bad_lines  out  CNT_W  lines completed with error_code!=0

Behaviour:
- Grammar, type 1: ^T@P: $R <= D#
- Grammar, type 2: ^T@P: *A <= D#
- Field widths:
  - T: 1..TIME_MAX_DIG decimal digits.
  - R: 1..REG_MAX_DIG decimal digits.
  - P, A, D: exactly HEX_DIG hex digits.
- Spaces: zero or more after ':', before '<', and after '='. No spaces anywhere else.
- States: IDLE, TIME, PC, COLON_SP, REG, MEM, PRE_LT, LT_EQ, POST_EQ, DATA, DONE1, DONE2.
- One transition per clock, using the current char.
- Any illegal char or a digit-count overflow sends the FSM to IDLE and clears all counters and accumulators.
- Exception: '^' in any state (including an error position and DONE) restarts at TIME with counters cleared. This is a resync on a new line.
- '#' is accepted only if DATA holds exactly HEX_DIG digits; it then moves to DONE1 or DONE2.
- In DONE1/DONE2 the next char follows the IDLE rules, so a '^' starts a new line.
- format_type:
  - 1 while state==DONE1, 2 while state==DONE2, else 0.
  - It asserts in the cycle after '#' is sampled and lasts exactly one cycle unless the stream stalls. A non-'^' char leaves DONE.
- Accumulators:
  - PC and address: shift-in of 4-bit nibbles, 32 bits wide.
  - Register number: value*10+digit in 14 bits, no wrap needed given REG_MAX_DIG<=4.
- error_code is valid only while format_type!=0 and is 0 otherwise:
  - bit0: PC<PC_LO, or PC>PC_HI, or PC[1:0]!=0.
  - bit1 (type 2 only): A>ADDR_HI or A[1:0]!=0.
  - bit2 (type 1 only): R>=REG_NUM.
  - bit3: always 0.
- Error evaluation is registered on the '#' edge together with the DONE state, so both appear in the same cycle.
- Reset: state IDLE, format_type 0, error_code 0, counters 0, accumulators 0.
- Reset mid-line discards the partial line.

Optional Feature:
- Macro: CPU_TRACE_LINE_COUNT_EN.
- Defined:
  - good_lines or bad_lines increments by 1 on the edge that enters DONE1/DONE2.
  - Counters saturate at all-ones; they do not wrap.
  - Counters clear only on reset.
- Undefined: good_lines and bad_lines are tied to 0 and no counter flops exist.

Test Plan:
- Feed "^10@00003010: $5 <= 0000abcd#" -> format_type=1 for one cycle after '#', error_code=0, good_lines=1.
- Feed "^7@00003012:*00002ffc<=12345678#" -> format_type=2, error_code=4'b0001, bad_lines=1.
- Feed "^3@00003000: $32 <=  00000001#" then "^3@00003000: *00003000 <= 00000001#" -> error_code 4'b0100, then 4'b0010.
- Feed "^12345@00003000: $1 <= 00000000#" (5 time digits) and a 7-digit data field -> format_type stays 0 and no counter changes.
- Feed "^1@0000^2@00003000: $0 <= ffffffff#" -> '^' resync, single type-1 result. With UPPER_HEX=0, "FFFFFFFF" in place of the data field -> no result.
- Assert reset mid-line, then send the tail "...<= 00000000#" -> no result. The next full line is classified normally.
